// File: rtl/frame_tx_param.sv
// Serial frame transmitter: start, length field, N data bytes, optional CRC-8, stop; each bit held B clk cycles.
// Optional CRC byte enabled by defining FRAME_TX_CRC_EN.
module frame_tx_param #(
    parameter int         MAX_BYTES  = 16,
    parameter int         LEN_W      = 4,
    parameter int         BAUD_W     = 8,
    parameter logic [7:0] CRC_POLY   = 8'h07,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tf,
    input  logic [LEN_W-1:0]       framesize,
    input  logic [8*MAX_BYTES-1:0] framebits,
    input  logic [BAUD_W-1:0]      baudrate,
    output logic                   TXI,
    output logic                   TX,
    output logic                   done,
    output logic                   err
);
    localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CW = (LEN_W > 8) ? $clog2(LEN_W) : 3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LEN, S_DATA, S_STOP
`ifdef FRAME_TX_CRC_EN
        , S_CRC
`endif
    } state_t;

    state_t                      state, state_d;
    logic [BAUD_W-1:0]           b_q, baud_cnt;
    logic [CW-1:0]               bit_cnt;
    logic [IW-1:0]               byte_idx, last_q;
    logic [LEN_W-1:0]            len_sh;
    logic [MAX_BYTES-1:0][7:0]   payload_q;
    logic                        bit_end, req_ok, len_last, byte_last;
`ifdef FRAME_TX_CRC_EN
    logic [7:0]                  crc_q, crc_next;
`endif

    // Range check done wide so MAX_BYTES need not fit in LEN_W bits
    assign req_ok    = (framesize != '0) && (32'(framesize) <= 32'(MAX_BYTES));
    assign bit_end   = (baud_cnt == b_q);
    assign len_last  = (bit_cnt == CW'(LEN_W - 1));
    assign byte_last = (bit_cnt[2:0] == 3'd7);
    assign TXI       = (state == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        TX      = IDLE_LEVEL;
        unique case (state)
            S_IDLE:  if (tf && req_ok) state_d = S_START;
            S_START: begin
                TX = ~IDLE_LEVEL;
                if (bit_end) state_d = S_LEN;
            end
            S_LEN: begin
                TX = len_sh[LEN_W-1];
                if (bit_end && len_last) state_d = S_DATA;
            end
            S_DATA: begin
                TX = payload_q[byte_idx][~bit_cnt[2:0]];
                if (bit_end && byte_last && byte_idx == last_q)
`ifdef FRAME_TX_CRC_EN
                    state_d = S_CRC;
`else
                    state_d = S_STOP;
`endif
            end
`ifdef FRAME_TX_CRC_EN
            S_CRC: begin
                TX = crc_q[~bit_cnt[2:0]];
                if (bit_end && byte_last) state_d = S_STOP;
            end
`endif
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FRAME_TX_CRC_EN
    // One serial CRC step per transmitted LEN/DATA bit
    assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ TX) ? CRC_POLY : 8'h00);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q       <= BAUD_W'(1);
            baud_cnt  <= BAUD_W'(1);
            bit_cnt   <= '0;
            byte_idx  <= '0;
            last_q    <= '0;
            len_sh    <= '0;
            payload_q <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef FRAME_TX_CRC_EN
            crc_q     <= '0;
`endif
        end else begin
            done <= (state == S_STOP) && bit_end;
            err  <= (state == S_IDLE) && tf && !req_ok;
            if (state == S_IDLE) begin
                if (tf && req_ok) begin
                    b_q       <= (baudrate == '0) ? BAUD_W'(1) : baudrate;
                    baud_cnt  <= BAUD_W'(1);
                    bit_cnt   <= '0;
                    byte_idx  <= '0;
                    last_q    <= IW'(framesize - LEN_W'(1));
                    len_sh    <= framesize;
                    payload_q <= framebits;
`ifdef FRAME_TX_CRC_EN
                    crc_q     <= '0;
`endif
                end
            end else if (bit_end) begin
                baud_cnt <= BAUD_W'(1);
                unique case (state)
                    S_LEN: begin
                        len_sh  <= len_sh << 1;
                        bit_cnt <= len_last ? '0 : bit_cnt + CW'(1);
`ifdef FRAME_TX_CRC_EN
                        crc_q   <= crc_next;
`endif
                    end
                    S_DATA: begin
                        bit_cnt <= byte_last ? '0 : bit_cnt + CW'(1);
                        if (byte_last) byte_idx <= byte_idx + IW'(1);
`ifdef FRAME_TX_CRC_EN
                        crc_q   <= crc_next;
`endif
                    end
`ifdef FRAME_TX_CRC_EN
                    S_CRC:   bit_cnt <= byte_last ? '0 : bit_cnt + CW'(1);
`endif
                    default: ;
                endcase
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_tx_param.sv
// Scoreboard bench for frame_tx_param: expected per-cycle TX levels are queued at request time and popped each cycle.
module tb_frame_tx_param;
    localparam int MB = 8;
    localparam int LW = 4;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tf = 1'b0;
    logic [LW-1:0]     framesize = '0;
    logic [8*MB-1:0]   framebits = '0;
    logic [BW-1:0]     baudrate = '0;
    logic              TXI, TX, done, err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_len = 0;
    logic exp_q[$];

    frame_tx_param #(.MAX_BYTES(MB), .LEN_W(LW), .BAUD_W(BW),
                     .CRC_POLY(8'h07), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .tf(tf), .framesize(framesize),
        .framebits(framebits), .baudrate(baudrate),
        .TXI(TXI), .TX(TX), .done(done), .err(err));

    always #5 clk = ~clk;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    function automatic void push_frame(input int n, input logic [8*MB-1:0] fb, input int b);
        logic [7:0]    crc = 8'h00;
        logic [LW-1:0] len = LW'(n);
        logic          q[$];
        int            e = (b == 0) ? 1 : b;
        q.push_back(1'b1);
        for (int i = LW - 1; i >= 0; i--) begin
            q.push_back(len[i]);
            crc = crc_step(crc, len[i]);
        end
        for (int k = 0; k < n; k++)
            for (int j = 7; j >= 0; j--) begin
                q.push_back(fb[8*k+j]);
                crc = crc_step(crc, fb[8*k+j]);
            end
`ifdef FRAME_TX_CRC_EN
        for (int i = 7; i >= 0; i--) q.push_back(crc[i]);
`endif
        q.push_back(1'b0);
        foreach (q[i]) repeat (e) exp_q.push_back(q[i]);
    endfunction

    // Runs from the first busy cycle to the completion cycle, comparing TX each cycle
    task automatic check_frame(input string name, input int switch_at,
                               input logic [LW-1:0] nsz, input logic [8*MB-1:0] nbits);
        int   cyc = 0;
        logic e;
        while (TXI === 1'b0 && cyc < 20000) begin
            if (cyc == switch_at) begin
                framesize = nsz;
                framebits = nbits;
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s frame too long: busy at cycle %0d, expected idle", name, cyc);
            end else begin
                e = exp_q.pop_front();
                if (TX !== e) begin
                    n_bad++;
                    $display("FAIL %s tx cycle %0d: got %b expected %b", name, cyc, TX, e);
                end
            end
            n_cmp++;
            if (done !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL %s pulses mid-frame cycle %0d: done=%b err=%b expected 0/0", name, cyc, done, err);
            end
            cyc++;
            @(negedge clk);
        end
        last_len = cyc;
        n_cmp++;
        if (TXI !== 1'b1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s length: busy %0d cycles, %0d expected levels left, TXI=%b expected 1",
                     name, cyc, exp_q.size(), TXI);
            exp_q.delete();
        end
        n_cmp++;
        if (done !== 1'b1 || TX !== 1'b0) begin
            n_bad++;
            $display("FAIL %s completion: done=%b TX=%b expected 1/0", name, done, TX);
        end
    endtask

    task automatic start_req(input int n, input logic [8*MB-1:0] fb, input int b, input logic hold);
        tf = 1'b1;
        framesize = LW'(n);
        framebits = fb;
        baudrate  = BW'(b);
        push_frame(n, fb, b);
        @(negedge clk);
        tf = hold;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (TXI !== 1'b1 || TX !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: TXI=%b TX=%b done=%b err=%b expected 1/0/0/0", TXI, TX, done, err);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spec_vector;
`ifdef FRAME_TX_CRC_EN
        logic [21:0] v = 22'b1_0001_10100101_01100111_0;
        int          bits = 22;
        int          want = 44;
`else
        logic [13:0] v = 14'b1_0001_10100101_0;
        int          bits = 14;
        int          want = 28;
`endif
        tf = 1'b1;
        framesize = LW'(1);
        framebits = '0;
        framebits[7:0] = 8'hA5;
        baudrate = BW'(2);
        for (int i = bits - 1; i >= 0; i--) repeat (2) exp_q.push_back(v[i]);
        @(negedge clk);
        tf = 1'b0;
        check_frame("spec_vector", -1, '0, '0);
        n_cmp++;
        if (last_len != want) begin
            n_bad++;
            $display("FAIL spec_vector busy cycles: got %0d expected %0d", last_len, want);
        end
        @(negedge clk);
    endtask

    task automatic test_reject;
        int sizes[3] = '{0, MB + 1, 15};
        foreach (sizes[i]) begin
            tf = 1'b1;
            framesize = LW'(sizes[i]);
            framebits = {$urandom, $urandom};
            baudrate = BW'(1);
            @(negedge clk);
            tf = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || TXI !== 1'b1 || TX !== 1'b0) begin
                n_bad++;
                $display("FAIL reject size %0d: err=%b TXI=%b TX=%b expected 1/1/0", sizes[i], err, TXI, TX);
            end
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || TXI !== 1'b1 || TX !== 1'b0) begin
                n_bad++;
                $display("FAIL reject size %0d after: err=%b TXI=%b TX=%b expected 0/1/0", sizes[i], err, TXI, TX);
            end
        end
    endtask

    task automatic test_baud;
        logic [8*MB-1:0] d = {$urandom, $urandom};
        int              bauds[3] = '{0, 1, 255};
        int              ns[3] = '{3, 3, 1};
        foreach (bauds[i]) begin
            start_req(ns[i], d, bauds[i], 1'b0);
            check_frame($sformatf("baud_%0d", bauds[i]), -1, '0, '0);
            @(negedge clk);
        end
        start_req(MB, {$urandom, $urandom}, 1, 1'b0);
        check_frame("max_bytes", -1, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [8*MB-1:0] d1 = {$urandom, $urandom};
        logic [8*MB-1:0] d2 = {$urandom, $urandom};
        start_req(2, d1, 3, 1'b1);
        framesize = '0;
        framebits = ~d1;
        baudrate  = BW'(7);
        check_frame("b2b_first", 12, LW'(2), d2);
        push_frame(2, d2, 7);
        @(negedge clk);
        tf = 1'b0;
        check_frame("b2b_second", -1, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        start_req(4, {$urandom, $urandom}, 2, 1'b0);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (TXI !== 1'b1 || TX !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: TXI=%b TX=%b done=%b expected 1/0/0", TXI, TX, done);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || TXI !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid after: done=%b TXI=%b expected 0/1", done, TXI);
        end
        start_req(5, {$urandom, $urandom}, 2, 1'b0);
        check_frame("after_reset", -1, '0, '0);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_spec_vector;
        test_reject;
        test_baud;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
